tlul_mem_slave: RTL and testbench
=================================

# tlul_mem_slave

Parametrised TileLink-UL memory slave, the successor to the single-outstanding 32-bit slave on the 24 MHz TileLink fabric. It adds configurable data width, depth and base address, and honours byte masks on PutPartialData. It supports up to RSP_DEPTH outstanding requests through a response FIFO, echoes a_source on channel D, denies malformed requests, and counts denials. It sits directly on a TL-UL host port as a local SRAM target.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; multiple of 8, at least 16
- MASK_WIDTH, DATA_WIDTH/8, byte-lane count
- SIZE_WIDTH, 3, a_size/d_size width
- OPCODE_WIDTH, 3, opcode width
- SOURCE_WIDTH, 4, source ID width
- MEM_DEPTH, 1024, words; power of two
- ADDR_BASE, 32'h4000_0000, byte base address; aligned to MEM_DEPTH*MASK_WIDTH
- RSP_DEPTH, 4, response FIFO entries; power of two, at least 2
- Clock and reset (decided): one clock, clk_24; reset rst_n is asynchronous and active-low.
- clk_24  in  1  clock
- rst_n  in  1  async active-low reset
- a_valid  in  1  request valid
- a_ready  out  1  request ready
- a_opcode  in  OPCODE_WIDTH  Get=0, PutFullData=1, PutPartialData=2
- a_size  in  SIZE_WIDTH  log2 bytes
- a_source  in  SOURCE_WIDTH  requester ID
- a_address  in  ADDR_WIDTH  byte address
- a_mask  in  MASK_WIDTH  byte enables
- a_data  in  DATA_WIDTH  write data
- d_valid  out  1  response valid
- d_ready  in  1  response ready
- d_opcode  out  OPCODE_WIDTH  AccessAck=0, AccessAckData=1
- d_size  out  SIZE_WIDTH  echoed a_size
- d_source  out  SOURCE_WIDTH  echoed a_source
- d_denied  out  1  request rejected
- d_data  out  DATA_WIDTH  read data
- denied_count  out  16  saturating count of denied requests

## Operation
- Accept: a_valid && a_ready. a_ready = !fifo_full. Each accept pushes exactly one response entry {opcode, size, source, denied, data}.
- A request is denied if any of the following holds:
  - address is outside [ADDR_BASE, ADDR_BASE + MEM_DEPTH*MASK_WIDTH)
  - opcode is not 0, 1 or 2
  - a_size > log2(MASK_WIDTH)
  - address is not aligned to 2^a_size
- Word index = (a_address − ADDR_BASE) >> log2(MASK_WIDTH), truncated to log2(MEM_DEPTH) bits.
- Put, not denied: on the accept edge, byte lane i is written if a_mask[i]. PutFullData uses the same masked write. Response is AccessAck with d_data = 0.
- Get, not denied: the word is read combinationally at accept and stored in the entry. Response is AccessAckData. Mask is ignored.
- Denied request:
  - memory is untouched
  - d_denied = 1, d_data = 0
  - opcode is AccessAckData for Get, AccessAck otherwise
  - denied_count increments, saturating at 16'hFFFF
- Responses are returned in acceptance order.
- Memory is NOT cleared by reset; contents are undefined until written.

## Timing
- Minimum latency: accept at edge N gives d_valid at N+1. Back-to-back accepts yield back-to-back responses while d_ready is high, i.e. one transaction per cycle of throughput.
- Read-after-write: a Get accepted the cycle after a Put to the same word returns the new data.
- d_* outputs come from the registered FIFO head. While d_valid && !d_ready, all d_* hold stable.
- Pop: d_valid && d_ready.
- Push and pop in the same cycle: count is unchanged, pointers both advance.
- Full (count == RSP_DEPTH): a_ready = 0. a_ready depends only on registered count; there is no combinational path from d_ready to a_ready. A pop at full raises a_ready the next cycle.
- Empty: d_valid = 0. Pointers wrap modulo RSP_DEPTH. Count width is log2(RSP_DEPTH)+1.
- Reset values:
  - a_ready = 1, d_valid = 0, d_denied = 0
  - d_opcode, d_size, d_source, d_data = 0
  - denied_count = 0, FIFO empty
- Reset mid-operation: outstanding responses are discarded, and an in-flight write on the reset edge is not performed.

## Structure
- Package tlul_pkg holds the A/D opcode localparams (Get, PutFullData, PutPartialData, AccessAck, AccessAckData) and the response-entry field widths.
- Sub-module tlul_rsp_fifo: a parametrised synchronous FIFO (width, depth) with full/empty/count outputs, used for the response queue.
- The top module holds decode/denial logic, the byte-masked memory array and denied_count.

## Test plan
- Put 0x4000_0010 data 0xCAFEBABE mask 0xF, then Get 0x4000_0010 → AccessAck, then AccessAckData 0xCAFEBABE, d_denied 0, d_source echoed.
- PutPartialData 0x4000_0010 data 0x1122_3344 mask 0b0101 over 0xCAFEBABE → Get returns 0xCA22BA44.
- Get 0x3FFF_FFFC, Get 0x4000_1000, Get 0x4000_0002 with size 2, opcode 3 → all d_denied 1, d_data 0, denied_count = 4, memory unchanged.
- Hold d_ready = 0 and issue 5 Gets → 4 accepted, a_ready low on the 5th; d_* stable. Release d_ready → responses in order with sources 0..3, then the 5th is accepted.
- Continuous a_valid and d_ready with alternating Put/Get to one word → one response per cycle, Gets see the preceding Put data.
- Assert rst_n with 3 entries queued → next cycle d_valid 0, a_ready 1, denied_count 0; a subsequent Get returns previously written data (memory retained).

Source files
------------

// File: rtl/tlul_pkg.sv
// Shared TileLink-UL encodings and response-entry field sizing for the memory slave.
package tlul_pkg;

    localparam int unsigned TL_GET              = 0;
    localparam int unsigned TL_PUT_FULL_DATA    = 1;
    localparam int unsigned TL_PUT_PARTIAL_DATA = 2;

    localparam int unsigned TL_ACCESS_ACK       = 0;
    localparam int unsigned TL_ACCESS_ACK_DATA  = 1;

    localparam int unsigned RSP_DENIED_W        = 1;

    function automatic int unsigned rsp_entry_width(
        input int unsigned opcode_w,
        input int unsigned size_w,
        input int unsigned source_w,
        input int unsigned data_w
    );
        return opcode_w + size_w + source_w + RSP_DENIED_W + data_w;
    endfunction

endpackage

// File: rtl/tlul_mem_slave_if.sv
// TL-UL A/D channel bundle for the memory slave, plus its denial counter output.
interface tlul_mem_slave_if #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned SIZE_WIDTH   = 3,
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned SOURCE_WIDTH = 4
) ();

    logic                    a_valid;
    logic                    a_ready;
    logic [OPCODE_WIDTH-1:0] a_opcode;
    logic [SIZE_WIDTH-1:0]   a_size;
    logic [SOURCE_WIDTH-1:0] a_source;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [MASK_WIDTH-1:0]   a_mask;
    logic [DATA_WIDTH-1:0]   a_data;

    logic                    d_valid;
    logic                    d_ready;
    logic [OPCODE_WIDTH-1:0] d_opcode;
    logic [SIZE_WIDTH-1:0]   d_size;
    logic [SOURCE_WIDTH-1:0] d_source;
    logic                    d_denied;
    logic [DATA_WIDTH-1:0]   d_data;

    logic [15:0]             denied_count;

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_size, d_source, d_denied, d_data,
        input  d_ready,
        output denied_count
    );

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_size, d_source, d_denied, d_data,
        output d_ready,
        input  denied_count
    );

endinterface

// File: rtl/tlul_rsp_fifo.sv
// Synchronous FIFO with registered pointers/count; head entry reads as zero when empty.
module tlul_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : store_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth lets the pointers wrap by plain overflow.
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok) count_d = count_q + 1'b1;
        if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) store_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/tlul_mem_slave.sv
// TL-UL SRAM target: request decode/denial, byte-masked memory, ordered response queue.
module tlul_mem_slave
    import tlul_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned SIZE_WIDTH   = 3,
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned SOURCE_WIDTH = 4,
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = 32'h4000_0000,
    parameter int unsigned RSP_DEPTH    = 4
) (
    input logic              clk_24,
    input logic              rst_n,
    tlul_mem_slave_if.slave  bus
);

    localparam int unsigned LANE_AW = $clog2(MASK_WIDTH);
    localparam int unsigned MEM_AW  = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W   = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned RSP_W   = rsp_entry_width(OPCODE_WIDTH, SIZE_WIDTH, SOURCE_WIDTH, DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * MASK_WIDTH);

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [SIZE_WIDTH-1:0]   size;
        logic [SOURCE_WIDTH-1:0] source;
        logic                    denied;
        logic [DATA_WIDTH-1:0]   data;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [MEM_AW-1:0]     word_idx;
    logic                  in_range, op_ok, size_ok, aligned;
    logic                  is_get, denied, accept, mem_we;
    rsp_t                  rsp_in, rsp_head;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      rsp_count;
    logic [15:0]           denied_cnt_q, denied_cnt_d;

    always_comb begin
        offset     = bus.a_address - ADDR_BASE;
        in_range   = (bus.a_address >= ADDR_BASE) && ({1'b0, offset} < MEM_BYTES);
        op_ok      = bus.a_opcode <= OPCODE_WIDTH'(TL_PUT_PARTIAL_DATA);
        size_ok    = bus.a_size <= SIZE_WIDTH'(LANE_AW);
        align_mask = ~({ADDR_WIDTH{1'b1}} << bus.a_size);
        aligned    = (bus.a_address & align_mask) == '0;
        denied     = !(in_range && op_ok && size_ok && aligned);
        is_get     = bus.a_opcode == OPCODE_WIDTH'(TL_GET);
        word_idx   = offset[LANE_AW +: MEM_AW];
        accept     = bus.a_valid && bus.a_ready;
        // Gating with rst_n keeps a write coincident with reset from landing.
        mem_we     = accept && !denied && !is_get && rst_n;
    end

    always_comb begin
        rsp_in        = '0;
        rsp_in.opcode = is_get ? OPCODE_WIDTH'(TL_ACCESS_ACK_DATA) : OPCODE_WIDTH'(TL_ACCESS_ACK);
        rsp_in.size   = bus.a_size;
        rsp_in.source = bus.a_source;
        rsp_in.denied = denied;
        if (is_get && !denied) rsp_in.data = mem_q[word_idx];
    end

    always_ff @(posedge clk_24) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                if (bus.a_mask[i]) mem_q[word_idx][8*i +: 8] <= bus.a_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        denied_cnt_d = denied_cnt_q;
        if (accept && denied && denied_cnt_q != '1) denied_cnt_d = denied_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_24 or negedge rst_n) begin
        if (!rst_n) denied_cnt_q <= '0;
        else        denied_cnt_q <= denied_cnt_d;
    end

    tlul_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_24),
        .rst_ni  (rst_n),
        .push_i  (accept),
        .wdata_i (rsp_in),
        .pop_i   (bus.d_valid && bus.d_ready),
        .rdata_o (rsp_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (rsp_count)
    );

    assign bus.a_ready      = !fifo_full;
    assign bus.d_valid      = !fifo_empty;
    assign bus.d_opcode     = rsp_head.opcode;
    assign bus.d_size       = rsp_head.size;
    assign bus.d_source     = rsp_head.source;
    assign bus.d_denied     = rsp_head.denied;
    assign bus.d_data       = rsp_head.data;
    assign bus.denied_count = denied_cnt_q;

    a_rsp_count_bound: assert property (@(posedge clk_24) disable iff (!rst_n)
        rsp_count <= CNT_W'(RSP_DEPTH));

endmodule

// File: tb/tb_tlul_mem_slave.sv
// Directed bench for tlul_mem_slave with hand-computed expectations and immediate assertions.
module tb_tlul_mem_slave;

    localparam logic [2:0] GET  = 3'd0;
    localparam logic [2:0] PUTF = 3'd1;
    localparam logic [2:0] PUTP = 3'd2;
    localparam logic [2:0] ACK  = 3'd0;
    localparam logic [2:0] ACKD = 3'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    tlul_mem_slave_if #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4),
        .SIZE_WIDTH(3), .OPCODE_WIDTH(3), .SOURCE_WIDTH(4)
    ) bus ();

    tlul_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4), .SIZE_WIDTH(3),
        .OPCODE_WIDTH(3), .SOURCE_WIDTH(4), .MEM_DEPTH(1024),
        .ADDR_BASE(32'h4000_0000), .RSP_DEPTH(4)
    ) dut (
        .clk_24 (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [2:0] op, input logic [3:0] src,
                         input logic den, input logic [31:0] data);
        check({tag, ".valid"},  32'(bus.d_valid),  32'd1);
        check({tag, ".opcode"}, 32'(bus.d_opcode), 32'(op));
        check({tag, ".source"}, 32'(bus.d_source), 32'(src));
        check({tag, ".denied"}, 32'(bus.d_denied), 32'(den));
        check({tag, ".data"},   bus.d_data,        data);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        bus.a_valid   = 1'b1;
        bus.a_opcode  = op;
        bus.a_size    = sz;
        bus.a_source  = src;
        bus.a_address = addr;
        bus.a_mask    = mask;
        bus.a_data    = data;
    endtask

    task automatic idle();
        bus.a_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_size = '0; bus.a_source = '0;
        bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0; bus.d_ready = 1'b1;

        // Reset state
        step(); step();
        check("rst.a_ready", 32'(bus.a_ready), 32'd1);
        check("rst.d_valid", 32'(bus.d_valid), 32'd0);
        check("rst.d_denied", 32'(bus.d_denied), 32'd0);
        check("rst.d_opcode", 32'(bus.d_opcode), 32'd0);
        check("rst.d_size", 32'(bus.d_size), 32'd0);
        check("rst.d_source", 32'(bus.d_source), 32'd0);
        check("rst.d_data", bus.d_data, 32'd0);
        check("rst.denied_count", 32'(bus.denied_count), 32'd0);
        #2 rst_n = 1'b1;
        step();

        // Full put then get
        issue(PUTF, 3'd2, 4'd5, 32'h4000_0010, 4'hF, 32'hCAFE_BABE);
        step();
        chk_d("put1", ACK, 4'd5, 1'b0, 32'h0);
        check("put1.d_size", 32'(bus.d_size), 32'd2);
        issue(GET, 3'd2, 4'd6, 32'h4000_0010, 4'h0, 32'h0);
        step();
        chk_d("get1", ACKD, 4'd6, 1'b0, 32'hCAFE_BABE);
        idle();
        step();
        check("get1.drain", 32'(bus.d_valid), 32'd0);

        // Partial put over lanes 0 and 2
        issue(PUTP, 3'd2, 4'd7, 32'h4000_0010, 4'b0101, 32'h1122_3344);
        step();
        chk_d("putp", ACK, 4'd7, 1'b0, 32'h0);
        issue(GET, 3'd2, 4'd8, 32'h4000_0010, 4'h0, 32'h0);
        step();
        chk_d("getp", ACKD, 4'd8, 1'b0, 32'hCA22_BA44);

        // Denials: below base, one past end, misaligned, bad opcode
        issue(GET, 3'd2, 4'd1, 32'h3FFF_FFFC, 4'h0, 32'h0);
        step();
        chk_d("den.below", ACKD, 4'd1, 1'b1, 32'h0);
        issue(GET, 3'd2, 4'd2, 32'h4000_1000, 4'h0, 32'h0);
        step();
        chk_d("den.end", ACKD, 4'd2, 1'b1, 32'h0);
        issue(GET, 3'd2, 4'd3, 32'h4000_0002, 4'h0, 32'h0);
        step();
        chk_d("den.align", ACKD, 4'd3, 1'b1, 32'h0);
        issue(3'd3, 3'd2, 4'd4, 32'h4000_0010, 4'hF, 32'hFFFF_FFFF);
        step();
        chk_d("den.opcode", ACK, 4'd4, 1'b1, 32'h0);
        idle();
        step();
        check("den.count4", 32'(bus.denied_count), 32'd4);
        issue(GET, 3'd2, 4'd9, 32'h4000_0010, 4'h0, 32'h0);
        step();
        chk_d("den.memkept", ACKD, 4'd9, 1'b0, 32'hCA22_BA44);
        issue(GET, 3'd3, 4'd10, 32'h4000_0000, 4'h0, 32'h0);
        step();
        chk_d("den.size", ACKD, 4'd10, 1'b1, 32'h0);
        idle();
        step();
        check("den.count5", 32'(bus.denied_count), 32'd5);

        // Last in-range word
        issue(PUTF, 3'd2, 4'd11, 32'h4000_0FFC, 4'hF, 32'hA5A5_0F0F);
        step();
        chk_d("last.put", ACK, 4'd11, 1'b0, 32'h0);
        issue(GET, 3'd2, 4'd12, 32'h4000_0FFC, 4'h0, 32'h0);
        step();
        chk_d("last.get", ACKD, 4'd12, 1'b0, 32'hA5A5_0F0F);
        idle();
        step();

        // Backpressure: fill four entries, fifth is held off
        bus.d_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(GET, 3'd2, 4'(i), 32'h4000_0010, 4'h0, 32'h0);
            check("bp.a_ready_pre", 32'(bus.a_ready), 32'd1);
            step();
        end
        issue(GET, 3'd2, 4'd4, 32'h4000_0010, 4'h0, 32'h0);
        check("bp.full", 32'(bus.a_ready), 32'd0);
        chk_d("bp.head", ACKD, 4'd0, 1'b0, 32'hCA22_BA44);
        step();
        check("bp.hold_ready", 32'(bus.a_ready), 32'd0);
        chk_d("bp.stable", ACKD, 4'd0, 1'b0, 32'hCA22_BA44);
        bus.d_ready = 1'b1;
        step();
        check("bp.reopen", 32'(bus.a_ready), 32'd1);
        check("bp.src1", 32'(bus.d_source), 32'd1);
        step();
        check("bp.pushpop_ready", 32'(bus.a_ready), 32'd1);
        check("bp.src2", 32'(bus.d_source), 32'd2);
        idle();
        step();
        check("bp.src3", 32'(bus.d_source), 32'd3);
        step();
        chk_d("bp.fifth", ACKD, 4'd4, 1'b0, 32'hCA22_BA44);
        step();
        check("bp.empty", 32'(bus.d_valid), 32'd0);

        // Streaming alternating put/get, one response per cycle
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                issue(PUTF, 3'd2, 4'(k), 32'h4000_0020, 4'hF, 32'hBEEF_0000 | 32'(k));
            else
                issue(GET, 3'd2, 4'(k), 32'h4000_0020, 4'h0, 32'h0);
            check("stream.a_ready", 32'(bus.a_ready), 32'd1);
            step();
            if (k % 2 == 0)
                chk_d("stream.put", ACK, 4'(k), 1'b0, 32'h0);
            else
                chk_d("stream.get", ACKD, 4'(k), 1'b0, 32'hBEEF_0000 | 32'(k - 1));
        end
        idle();
        step();

        // Reset with three queued; a put during reset must not land
        bus.d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(GET, 3'd2, 4'(9 + i), 32'h4000_0FFC, 4'h0, 32'h0);
            step();
        end
        check("rq.queued", 32'(bus.d_valid), 32'd1);
        issue(PUTF, 3'd2, 4'd13, 32'h4000_0FFC, 4'hF, 32'hDEAD_DEAD);
        rst_n = 1'b0;
        step();
        check("rq.d_valid", 32'(bus.d_valid), 32'd0);
        check("rq.a_ready", 32'(bus.a_ready), 32'd1);
        check("rq.denied_count", 32'(bus.denied_count), 32'd0);
        check("rq.d_data", bus.d_data, 32'd0);
        idle();
        rst_n = 1'b1;
        bus.d_ready = 1'b1;
        issue(GET, 3'd2, 4'd12, 32'h4000_0FFC, 4'h0, 32'h0);
        step();
        chk_d("rq.retained", ACKD, 4'd12, 1'b0, 32'hA5A5_0F0F);
        issue(GET, 3'd2, 4'd14, 32'h4000_0020, 4'h0, 32'h0);
        step();
        chk_d("rq.retained2", ACKD, 4'd14, 1'b0, 32'hBEEF_0004);
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
